// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the LC-3b decode/issue hazard controller:
// branch-shadow FSM encoding, register-id width and default sizing.
package pipe_hazard_ctrl_pkg;

    localparam int REG_ID_W  = 3;
    localparam int NREG_DEF  = 8;
    localparam int CNT_W_DEF = 2;

    typedef enum logic {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } brState_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sb_counter.sv
// Pending-write counter for one scoreboard entry: increments on issue, decrements on retire,
// saturates at both ends and flags a retire that arrives with nothing pending.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    // A simultaneous issue and retire of the same entry leaves the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt       = r_cnt;
    assign o_underflow = i_dec && (r_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode/issue sequencing: registered pending-write scoreboard, branch-shadow FSM and FE/DE/AGEX
// latch control. Defining PIPE_WB_BYPASS_EN lets a same-cycle final retire clear a source hit.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                de_v,
    input  logic [REG_ID_W-1:0] de_sr1,
    input  logic [REG_ID_W-1:0] de_sr2,
    input  logic                de_sr1_needed,
    input  logic                de_sr2_needed,
    input  logic [REG_ID_W-1:0] de_dr,
    input  logic                de_ld_reg,
    input  logic                de_ld_cc,
    input  logic                de_br_op,
    input  logic                de_br_stall,
    input  logic                br_resolve,
    input  logic                mem_stall,
    input  logic                icache_stall,
    input  logic                sr_v,
    input  logic                sr_ld_reg,
    input  logic                sr_ld_cc,
    input  logic [REG_ID_W-1:0] sr_drid,
    output logic                dep_stall,
    output logic                agex_v,
    output logic                ld_agex,
    output logic                ld_de,
    output logic                ld_pc,
    output logic                de_next_v,
    output logic                br_wait,
    output logic [NREG-1:0]     pend_mask,
    output logic                sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] w_regCnt [NREG];
    logic [NREG-1:0]  w_regInc, w_regDec, w_regUf;
    logic [CNT_W-1:0] w_ccCnt;
    logic             w_ccUf;
    logic             w_issue, w_retire, w_retireCc, w_brBlock, w_errSet;
    logic             w_sr1Hit, w_sr2Hit, w_ccHit, w_satHit;
    brState_t         r_state, w_nextState;
    logic             r_sbErr;

    assign w_retire   = sr_v & sr_ld_reg;
    assign w_retireCc = sr_v & sr_ld_cc;

    for (genvar g = 0; g < NREG; g++) begin : gRegCnt
        sb_counter #(.CNT_W(CNT_W)) uCnt (
            .clk(clk), .reset_n(reset_n), .i_inc(w_regInc[g]), .i_dec(w_regDec[g]),
            .o_cnt(w_regCnt[g]), .o_underflow(w_regUf[g])
        );
    end

    sb_counter #(.CNT_W(CNT_W)) uCcCnt (
        .clk(clk), .reset_n(reset_n), .i_inc(w_issue & de_ld_cc), .i_dec(w_retireCc),
        .o_cnt(w_ccCnt), .o_underflow(w_ccUf)
    );

    always_comb begin
        w_sr1Hit = de_sr1_needed && (w_regCnt[de_sr1] != '0);
        w_sr2Hit = de_sr2_needed && (w_regCnt[de_sr2] != '0);
        w_ccHit  = de_br_op && (w_ccCnt != '0);
        w_satHit = de_ld_reg && (w_regCnt[de_dr] == CNT_MAX);
`ifdef PIPE_WB_BYPASS_EN
        // The register file writes mid-cycle, so the last outstanding write can be read now.
        if (w_retire && (sr_drid == de_sr1) && (w_regCnt[de_sr1] == CNT_ONE)) w_sr1Hit = 1'b0;
        if (w_retire && (sr_drid == de_sr2) && (w_regCnt[de_sr2] == CNT_ONE)) w_sr2Hit = 1'b0;
        if (w_retireCc && (w_ccCnt == CNT_ONE)) w_ccHit = 1'b0;
`endif
    end

    assign dep_stall = de_v & (w_sr1Hit | w_sr2Hit | w_ccHit | w_satHit);
    assign w_issue   = de_v & ~dep_stall & ~mem_stall;

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_regInc[i] = w_issue && de_ld_reg && (de_dr == REG_ID_W'(i));
            w_regDec[i] = w_retire && (sr_drid == REG_ID_W'(i));
            pend_mask[i] = (w_regCnt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A branch issuing in the same cycle as an older one resolves keeps fetch blocked.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN:     if (w_issue && de_br_stall) w_nextState = BR_WAIT;
            BR_WAIT: if (!(w_issue && de_br_stall) && br_resolve) w_nextState = RUN;
        endcase
    end

    always_comb begin
        br_wait   = (r_state == BR_WAIT);
        w_brBlock = br_wait | (w_issue & de_br_stall);
        ld_agex   = ~mem_stall;
        agex_v    = w_issue;
        ld_de     = ~mem_stall & ~dep_stall;
        ld_pc     = ld_de & ~icache_stall & ~w_brBlock;
        de_next_v = ~icache_stall & ~w_brBlock;
    end

    assign w_errSet = (|w_regUf) | w_ccUf | (br_resolve & (r_state == RUN));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sbErr <= 1'b0;
        end else if (w_errSet) begin
            r_sbErr <= 1'b1;
        end
    end

    assign sb_err = r_sbErr;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed by random traffic,
// all compared against a pending-write-count model of the pipeline.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       de_v, de_sr1_needed, de_sr2_needed, de_ld_reg, de_ld_cc, de_br_op, de_br_stall;
    logic [2:0] de_sr1, de_sr2, de_dr, sr_drid;
    logic       br_resolve, mem_stall, icache_stall, sr_v, sr_ld_reg, sr_ld_cc;
    logic       dep_stall, agex_v, ld_agex, ld_de, ld_pc, de_next_v, br_wait, sb_err;
    logic [7:0] pend_mask;

`ifdef PIPE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int MAXCNT = 3;

    int checks = 0;
    int errors = 0;

    int pend [8];
    int ccPend;
    bit inBranch;
    bit errFlag;

    bit       expDep, expIssue, expBrBlock;
    bit [7:0] expMask;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset_n(reset_n), .de_v(de_v), .de_sr1(de_sr1), .de_sr2(de_sr2),
        .de_sr1_needed(de_sr1_needed), .de_sr2_needed(de_sr2_needed), .de_dr(de_dr),
        .de_ld_reg(de_ld_reg), .de_ld_cc(de_ld_cc), .de_br_op(de_br_op), .de_br_stall(de_br_stall),
        .br_resolve(br_resolve), .mem_stall(mem_stall), .icache_stall(icache_stall),
        .sr_v(sr_v), .sr_ld_reg(sr_ld_reg), .sr_ld_cc(sr_ld_cc), .sr_drid(sr_drid),
        .dep_stall(dep_stall), .agex_v(agex_v), .ld_agex(ld_agex), .ld_de(ld_de), .ld_pc(ld_pc),
        .de_next_v(de_next_v), .br_wait(br_wait), .pend_mask(pend_mask), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic clearInputs();
        de_v = 0; de_sr1 = 0; de_sr2 = 0; de_sr1_needed = 0; de_sr2_needed = 0; de_dr = 0;
        de_ld_reg = 0; de_ld_cc = 0; de_br_op = 0; de_br_stall = 0; br_resolve = 0;
        mem_stall = 0; icache_stall = 0; sr_v = 0; sr_ld_reg = 0; sr_ld_cc = 0; sr_drid = 0;
    endtask

    task automatic resetModel();
        for (int i = 0; i < 8; i++) pend[i] = 0;
        ccPend = 0; inBranch = 0; errFlag = 0;
    endtask

    // A source is busy while any write to it is outstanding, unless the bypass lets the final one through.
    function automatic bit srcBusy(input int r);
        bit retire = sr_v && sr_ld_reg;
        return (pend[r] > 0) && !(BYPASS && retire && (int'(sr_drid) == r) && (pend[r] == 1));
    endfunction

    function automatic void computeExpected();
        bit retireCc = sr_v && sr_ld_cc;
        bit anyHit;
        anyHit = (de_sr1_needed && srcBusy(int'(de_sr1))) || (de_sr2_needed && srcBusy(int'(de_sr2)))
              || (de_br_op && ccPend > 0 && !(BYPASS && retireCc && ccPend == 1))
              || (de_ld_reg && pend[de_dr] == MAXCNT);
        expDep     = de_v && anyHit;
        expIssue   = de_v && !expDep && !mem_stall;
        expBrBlock = inBranch || (expIssue && de_br_stall);
        for (int i = 0; i < 8; i++) expMask[i] = (pend[i] > 0);
    endfunction

    task automatic checkAll();
        computeExpected();
        checkOutput("dep_stall", dep_stall, expDep);
        checkOutput("agex_v", agex_v, expIssue);
        checkOutput("ld_agex", ld_agex, !mem_stall);
        checkOutput("ld_de", ld_de, !mem_stall && !expDep);
        checkOutput("ld_pc", ld_pc, !mem_stall && !expDep && !icache_stall && !expBrBlock);
        checkOutput("de_next_v", de_next_v, !icache_stall && !expBrBlock);
        checkOutput("br_wait", br_wait, inBranch);
        checkOutput("pend_mask", pend_mask, expMask);
        checkOutput("sb_err", sb_err, errFlag);
    endtask

    task automatic updateModel();
        bit retire = sr_v && sr_ld_reg;
        bit retireCc = sr_v && sr_ld_cc;
        computeExpected();
        if (retire && pend[sr_drid] == 0) errFlag = 1;
        if (retireCc && ccPend == 0) errFlag = 1;
        if (br_resolve && !inBranch) errFlag = 1;
        if (expIssue && de_ld_reg) pend[de_dr] += 1;
        if (retire) pend[sr_drid] -= 1;
        if (pend[sr_drid] < 0) pend[sr_drid] = 0;
        if (expIssue && de_ld_cc) ccPend += 1;
        if (retireCc) ccPend -= 1;
        if (ccPend < 0) ccPend = 0;
        if (expIssue && de_br_stall) inBranch = 1;
        else if (br_resolve) inBranch = 0;
    endtask

    task automatic stepCycle();
        #1 checkAll();
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    // Reset is pulsed between clock edges to show it acts without waiting for clk.
    task automatic doReset();
        #2 reset_n = 0;
        #1 resetModel();
        clearInputs();
        checkOutput("rstMask", pend_mask, 8'h00);
        checkOutput("rstBrWait", br_wait, 0);
        checkOutput("rstSbErr", sb_err, 0);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic applyStimulus();
        int r;
        clearInputs();
        de_v = ($urandom_range(0, 3) != 0);
        de_sr1 = 3'($urandom_range(0, 7)); de_sr1_needed = $urandom_range(0, 1) != 0;
        de_sr2 = 3'($urandom_range(0, 7)); de_sr2_needed = $urandom_range(0, 2) == 0;
        de_dr = 3'($urandom_range(0, 7)); de_ld_reg = $urandom_range(0, 1) != 0;
        de_ld_cc = $urandom_range(0, 3) == 0; de_br_op = $urandom_range(0, 3) == 0;
        de_br_stall = $urandom_range(0, 7) == 0;
        mem_stall = $urandom_range(0, 3) == 0; icache_stall = $urandom_range(0, 3) == 0;
        r = $urandom_range(0, 7);
        sr_drid = 3'(r);
        if (pend[r] > 0 && $urandom_range(0, 2) != 0) begin sr_v = 1; sr_ld_reg = 1; end
        if (ccPend > 0 && $urandom_range(0, 1) != 0) begin sr_v = 1; sr_ld_cc = 1; end
        br_resolve = inBranch && ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        reset_n = 0;
        clearInputs();
        resetModel();
        #7;
        checkOutput("rstPendMask", pend_mask, 8'h00);
        checkOutput("rstDepStall", dep_stall, 0);
        checkOutput("rstLdDe", ld_de, 1);
        checkOutput("rstLdPc", ld_pc, 1);
        checkOutput("rstBrWait0", br_wait, 0);
        @(negedge clk);
        reset_n = 1;
        stepCycle();

        // ADD R3 followed by a reader of R3
        clearInputs(); de_v = 1; de_dr = 3; de_ld_reg = 1;
        stepCycle();
        clearInputs(); de_v = 1; de_sr1 = 3; de_sr1_needed = 1;
        #1 checkOutput("r3Stall", dep_stall, 1);
        checkOutput("r3Mask", pend_mask, 8'h08);
        stepCycle(); stepCycle();
        sr_v = 1; sr_ld_reg = 1; sr_drid = 3;
        #1 checkOutput("r3RetireCycle", dep_stall, !BYPASS);
        stepCycle();
        sr_v = 0; sr_ld_reg = 0;
        #1 checkOutput("r3Released", dep_stall, 0);
        stepCycle();

        // Saturate R5, then free one slot
        clearInputs(); de_v = 1; de_dr = 5; de_ld_reg = 1;
        repeat (3) stepCycle();
        #1 checkOutput("r5SatStall", dep_stall, 1);
        checkOutput("r5Mask", pend_mask, 8'h20);
        stepCycle();
        sr_v = 1; sr_ld_reg = 1; sr_drid = 5;
        stepCycle();
        sr_v = 0; sr_ld_reg = 0;
        #1 checkOutput("r5Issue", agex_v, 1);
        stepCycle();
        clearInputs(); sr_v = 1; sr_ld_reg = 1; sr_drid = 5;
        repeat (3) stepCycle();

        // Branch shadow
        clearInputs(); de_v = 1; de_br_stall = 1;
        #1 checkOutput("brIssueLdPc", ld_pc, 0);
        stepCycle();
        clearInputs();
        for (int k = 0; k < 4; k++) begin
            #1 checkOutput("brWaitHeld", br_wait, 1);
            checkOutput("brLdPcHeld", ld_pc, 0);
            checkOutput("brDeNextV", de_next_v, 0);
            stepCycle();
        end
        br_resolve = 1;
        stepCycle();
        br_resolve = 0;
        #1 checkOutput("brResolved", br_wait, 0);
        checkOutput("brLdPcBack", ld_pc, 1);
        stepCycle();

        // mem_stall freezes issue but not retire
        clearInputs(); de_v = 1; de_dr = 2; de_ld_reg = 1;
        stepCycle();
        clearInputs(); mem_stall = 1; de_v = 1; de_dr = 4; de_ld_reg = 1;
        sr_v = 1; sr_ld_reg = 1; sr_drid = 2;
        #1 checkOutput("memAgexV", agex_v, 0);
        checkOutput("memLdDe", ld_de, 0);
        checkOutput("memLdAgex", ld_agex, 0);
        stepCycle();
        clearInputs();
        #1 checkOutput("memFrozenMask", pend_mask, 8'h00);
        stepCycle();

        // CC dependency
        clearInputs(); de_v = 1; de_ld_cc = 1;
        stepCycle();
        clearInputs(); de_v = 1; de_br_op = 1;
        #1 checkOutput("ccStall", dep_stall, 1);
        stepCycle();
        sr_v = 1; sr_ld_cc = 1;
        stepCycle();
        clearInputs(); de_v = 1; de_br_op = 1;
        stepCycle();

        for (int n = 0; n < 400; n++) begin
            applyStimulus();
            stepCycle();
        end

        // Sticky error from a retire with nothing pending
        doReset();
        sr_v = 1; sr_ld_reg = 1; sr_drid = 6;
        stepCycle();
        clearInputs();
        for (int k = 0; k < 3; k++) begin
            #1 checkOutput("sbErrHeld", sb_err, 1);
            stepCycle();
        end
        doReset();
        br_resolve = 1;
        stepCycle();
        clearInputs();
        #1 checkOutput("sbErrBrRun", sb_err, 1);
        stepCycle();
        doReset();
        stepCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
